fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of `decode_stage`. It owns the program counter and the instruction memory, and fetches one word per advance cycle. It presents the fetched instruction and PC+4 as registered outputs that `decode_stage` latches on `i_valid`. It also supports program loading from the debug unit, branch/jump redirection, hazard stalls and HALT detection.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_stage_instruction_memory.sv | 30 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and fetch-state encoding for the MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

    localparam int FETCH_STATE_W = 2;
    typedef logic [FETCH_STATE_W-1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE   = 2'd0;
    localparam fetch_state_t FETCH_RUN    = 2'd1;
    localparam fetch_state_t FETCH_HALTED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Word-addressed instruction store, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int N_BITS      = 32,
    parameter int N_BITS_ADDR = 8
) (
    input  logic                   i_clock,
    input  logic                   i_write_enable,
    input  logic [N_BITS_ADDR-1:0] i_write_addr,
    input  logic [N_BITS-1:0]      i_write_data,
    input  logic [N_BITS_ADDR-1:0] i_read_addr,
    output logic [N_BITS-1:0]      o_read_data
);

    logic [N_BITS-1:0] r_mem [0:(2**N_BITS_ADDR)-1];

    always_ff @(posedge i_clock) begin
        if (i_write_enable) begin
            r_mem[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = r_mem[i_read_addr];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC, instruction memory, redirect/stall/HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter int N_BITS      = 32,
    parameter int N_BITS_ADDR = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_pc_src,
    input  logic [N_BITS-1:0]      i_pc_target,
    input  logic                   i_mem_write,
    input  logic [N_BITS_ADDR-1:0] i_mem_write_addr,
    input  logic [N_BITS-1:0]      i_mem_write_data,
    output logic [N_BITS-1:0]      o_instruction,
    output logic [N_BITS-1:0]      o_pc_next,
    output logic [N_BITS-1:0]      o_pc,
    output logic                   o_valid,
    output logic                   o_halt
);

    fetch_state_t          r_state;
    logic [N_BITS-1:0]     r_pc;
    logic [N_BITS-1:0]     r_instruction;
    logic [N_BITS-1:0]     r_pc_next;
    logic                  r_valid;
    logic                  r_halt;

    logic [N_BITS-1:0]      w_fetch_word;
    logic [N_BITS-1:0]      w_pc_plus4;
    logic [N_BITS_ADDR-1:0] w_index;
    logic                   w_advance;
    logic                   w_is_halt;
    logic                   w_mem_we;
    logic                   w_unused;

    assign w_index    = r_pc[N_BITS_ADDR+1:2];
    assign w_pc_plus4 = r_pc + N_BITS'(PC_INCR);
    assign w_advance  = (r_state == FETCH_RUN) && i_enable;
    assign w_is_halt  = (w_fetch_word == N_BITS'(HALT_WORD));
    assign w_mem_we   = i_mem_write && (r_state == FETCH_IDLE);
    assign w_unused   = ^i_pc_target[1:0];

    instruction_memory #(
        .N_BITS      (N_BITS),
        .N_BITS_ADDR (N_BITS_ADDR)
    ) u_instruction_memory (
        .i_clock        (i_clock),
        .i_write_enable (w_mem_we),
        .i_write_addr   (i_mem_write_addr),
        .i_write_data   (i_mem_write_data),
        .i_read_addr    (w_index),
        .o_read_data    (w_fetch_word)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= FETCH_IDLE;
            r_pc          <= '0;
            r_instruction <= '0;
            r_pc_next     <= '0;
            r_valid       <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                FETCH_IDLE: if (i_start) r_state <= FETCH_RUN;
                FETCH_RUN:  if (w_advance && !i_pc_src && !i_stall && w_is_halt)
                                r_state <= FETCH_HALTED;
                default:    r_state <= r_state;
            endcase

            if (w_advance) begin
                if (i_pc_src) begin
                    // The word read this cycle is wrong-path; emit a bubble instead.
                    r_pc          <= {i_pc_target[N_BITS-1:2], 2'b00};
                    r_instruction <= N_BITS'(NOP_WORD);
                    r_pc_next     <= w_pc_plus4;
                    r_valid       <= 1'b1;
                end else if (!i_stall) begin
                    r_instruction <= w_fetch_word;
                    r_pc_next     <= w_pc_plus4;
                    r_valid       <= 1'b1;
                    // HALT is forwarded downstream but the PC parks on it.
                    if (w_is_halt) begin
                        r_halt <= 1'b1;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_next     = r_pc_next;
    assign o_pc          = r_pc;
    assign o_valid       = r_valid;
    assign o_halt        = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Vector-table bench for fetch_stage with a valid-word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_pc_src = 1'b0;
    logic [31:0] i_pc_target = '0;
    logic        i_mem_write = 1'b0;
    logic [7:0]  i_mem_write_addr = '0;
    logic [31:0] i_mem_write_data = '0;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_next;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        o_halt;

    fetch_stage #(.N_BITS(32), .N_BITS_ADDR(8)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_enable         (i_enable),
        .i_stall          (i_stall),
        .i_pc_src         (i_pc_src),
        .i_pc_target      (i_pc_target),
        .i_mem_write      (i_mem_write),
        .i_mem_write_addr (i_mem_write_addr),
        .i_mem_write_data (i_mem_write_data),
        .o_instruction    (o_instruction),
        .o_pc_next        (o_pc_next),
        .o_pc             (o_pc),
        .o_valid          (o_valid),
        .o_halt           (o_halt)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        rst, start, en, stall, pc_src;
        logic [31:0] target;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        e_valid;
        logic [31:0] e_instr, e_pnext, e_pc;
        logic        e_halt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pnext;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, start, en, stall, pc_src,
                                input logic [31:0] target, input logic we,
                                input logic [7:0] waddr, input logic [31:0] wdata,
                                input logic ev, input logic [31:0] ei, epn, epc,
                                input logic eh);
        vec_t v;
        v.rst = rst; v.start = start; v.en = en; v.stall = stall; v.pc_src = pc_src;
        v.target = target; v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.e_valid = ev; v.e_instr = ei; v.e_pnext = epn; v.e_pc = epc; v.e_halt = eh;
        return v;
    endfunction

    task automatic check32(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%08h expected=%08h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        sb_t s;
        i_reset = v.rst; i_start = v.start; i_enable = v.en; i_stall = v.stall;
        i_pc_src = v.pc_src; i_pc_target = v.target; i_mem_write = v.we;
        i_mem_write_addr = v.waddr; i_mem_write_data = v.wdata;
        if (v.e_valid) begin
            s.instr = v.e_instr;
            s.pnext = v.e_pnext;
            sb_q.push_back(s);
        end
        @(posedge i_clock);
        #1;
        check32("valid", idx, {31'b0, o_valid}, {31'b0, v.e_valid});
        check32("instr", idx, o_instruction, v.e_instr);
        check32("pc_next", idx, o_pc_next, v.e_pnext);
        check32("pc", idx, o_pc, v.e_pc);
        check32("halt", idx, {31'b0, o_halt}, {31'b0, v.e_halt});
        if (o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected vec=%0d got=%08h expected=none", idx, o_instruction);
            end else begin
                s = sb_q.pop_front();
                check32("sb_instr", idx, o_instruction, s.instr);
                check32("sb_pnext", idx, o_pc_next, s.pnext);
            end
        end
    endtask

    localparam logic [31:0] H = 32'hFFFF_FFFF;

    initial begin
        // rst start en stall src target we addr data | valid instr pnext pc halt
        vecs.push_back(mk(1,0,0,0,0, 0, 0,0,0,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 1,0,32'h20010005, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 1,1,32'h20020003, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 1,2,H,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 1,3,32'h11111111, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 1,4,32'h44444444, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 1,5,32'h55555555, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,1,0,0, 0, 0,0,0,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h20010005, 4, 4, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h20020003, 8, 8, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, H, 12, 8, 1));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          0, H, 12, 8, 1));
        vecs.push_back(mk(0,0,1,0,1, 0, 0,0,0,          0, H, 12, 8, 1));
        // Reset out of HALTED, then stall / redirect / single-step
        vecs.push_back(mk(1,0,0,0,0, 0, 0,0,0,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 0, 0,0,0,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 0,0,0,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h20010005, 4, 4, 0));
        vecs.push_back(mk(0,0,1,1,0, 0, 0,0,0,          0, 32'h20010005, 4, 4, 0));
        vecs.push_back(mk(0,0,1,1,0, 0, 0,0,0,          0, 32'h20010005, 4, 4, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h20020003, 8, 8, 0));
        vecs.push_back(mk(0,0,1,0,1, 32'h13, 0,0,0,     1, 0, 12, 32'h10, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h44444444, 32'h14, 32'h14, 0));
        vecs.push_back(mk(0,0,1,1,1, 32'h0C, 0,0,0,     1, 0, 32'h18, 32'h0C, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h11111111, 32'h10, 32'h10, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 0,0,0,          0, 32'h11111111, 32'h10, 32'h10, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h44444444, 32'h14, 32'h14, 0));
        vecs.push_back(mk(0,0,0,0,0, 0, 0,0,0,          0, 32'h44444444, 32'h14, 32'h14, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 1,0,32'hDEADBEEF, 1, 32'h55555555, 32'h18, 32'h18, 0));
        vecs.push_back(mk(0,0,0,1,1, 0, 0,0,0,          0, 32'h55555555, 32'h18, 32'h18, 0));
        // Restart: mem[0] must be intact; write coincident with start lands
        vecs.push_back(mk(1,0,0,0,0, 0, 0,0,0,          0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 0, 1,6,32'h66666666, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h20010005, 4, 4, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h20020003, 8, 8, 0));
        vecs.push_back(mk(0,0,1,0,1, 32'h18, 0,0,0,     1, 0, 12, 32'h18, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, 32'h66666666, 32'h1C, 32'h1C, 0));
        vecs.push_back(mk(0,0,1,0,1, 32'h0B, 0,0,0,     1, 0, 32'h20, 32'h08, 0));
        vecs.push_back(mk(0,0,1,0,0, 0, 0,0,0,          1, H, 12, 8, 1));
        vecs.push_back(mk(0,0,0,0,0, 0, 0,0,0,          0, H, 12, 8, 1));

        @(posedge i_clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
